range_ping_ctrl: RTL and testbench

//  Upstream producer for the range-sensor FWFT FIFO. Fires the ultrasonic trigger pulse and

---
 rtl/range_ping_ctrl_if.sv | 12 +
 rtl/range_ping_ctrl.sv | 178 +++++++++++++++++
 tb/tb_range_ping_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/range_ping_ctrl_if.sv
// FIFO write-side bundle between the range ping controller and the range-sample FIFO.
// The controller is the master: it drives the write strobe and data and watches the full flag.
interface range_ping_ctrl_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  wr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  fifo_full;

   modport master (output wr, output wr_data, input fifo_full);
   modport slave  (input wr, input wr_data, output fifo_full);
endinterface

// File: rtl/range_ping_ctrl.sv
// Ultrasonic ranging controller: fires trigger pulses at a fixed period, times the echo in
// microsecond ticks and writes one sample per ping (all-ones when the echo is missing or too long).
module range_ping_ctrl #(
   parameter int DATA_WIDTH  = 16,
   parameter int TICK_DIV    = 100,
   parameter int TRIG_CYCLES = 1000,
   parameter int TIMEOUT_US  = 30000,
   parameter int PERIOD_US   = 60000
) (
   input  logic              clk,
   input  logic              rs_n,
   input  logic              en,
   input  logic              echo,
   range_ping_ctrl_if.master fifo,
   output logic              trig,
   output logic              busy,
   output logic [7:0]        drop_cnt
);
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TRG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
   localparam int PER_W = $clog2(PERIOD_US + 1);
   localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [TRG_W-1:0]      TRG_LAST = TRG_W'(TRIG_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] TMO_LAST = DATA_WIDTH'(TIMEOUT_US - 1);
   localparam logic [PER_W-1:0]      PER_LAST = PER_W'(PERIOD_US - 1);
   localparam logic [PER_W-1:0]      PER_END  = PER_W'(PERIOD_US);
   localparam logic [DATA_WIDTH-1:0] NO_ECHO  = {DATA_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_ECHO = 3'd2,
      MEASURE   = 3'd3,
      PUSH      = 3'd4,
      HOLDOFF   = 3'd5
   } state_t;

   state_t                state_r, state_s;
   logic                  echo_meta_r, echo_sync_r, echo_prev_r;
   logic                  echo_rise_s, echo_fall_s;
   logic [TRG_W-1:0]      trig_cnt_r;
   logic [DIV_W-1:0]      meas_div_r, per_div_r;
   logic [DATA_WIDTH-1:0] meas_cnt_r, sample_s, wr_data_r;
   logic [PER_W-1:0]      per_cnt_r;
   logic                  meas_tick_s, per_tick_s, per_done_s, meas_sat_s;
   logic                  trig_r, busy_r, wr_r;
   logic [7:0]            drop_cnt_r;

   assign echo_rise_s = echo_sync_r & ~echo_prev_r;
   assign echo_fall_s = ~echo_sync_r & echo_prev_r;
   assign meas_tick_s = (meas_div_r == DIV_LAST);
   assign meas_sat_s  = meas_tick_s && (meas_cnt_r == TMO_LAST);
   assign per_tick_s  = (per_div_r == DIV_LAST);
   assign per_done_s  = (per_cnt_r == PER_END) || (per_tick_s && (per_cnt_r == PER_LAST));

   // Two-flop echo synchroniser plus a delayed copy for edge detection.
   always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) begin
         echo_meta_r <= 1'b0;
         echo_sync_r <= 1'b0;
         echo_prev_r <= 1'b0;
      end else begin
         echo_meta_r <= echo;
         echo_sync_r <= echo_meta_r;
         echo_prev_r <= echo_sync_r;
      end
   end

   // Next-state and sample selection; timeout/saturation take priority over echo edges.
   always_comb begin
      state_s  = state_r;
      sample_s = NO_ECHO;
      case (state_r)
         IDLE: begin
            if (en) state_s = TRIG;
            else    state_s = IDLE;
         end
         TRIG: begin
            if (trig_cnt_r == TRG_LAST) state_s = WAIT_ECHO;
            else                        state_s = TRIG;
         end
         WAIT_ECHO: begin
            if (meas_sat_s)       state_s = PUSH;
            else if (echo_rise_s) state_s = MEASURE;
            else                  state_s = WAIT_ECHO;
         end
         MEASURE: begin
            if (meas_sat_s) begin
               state_s = PUSH;
            end else if (echo_fall_s) begin
               state_s  = PUSH;
               sample_s = meas_cnt_r + {{(DATA_WIDTH-1){1'b0}}, meas_tick_s};
            end else begin
               state_s = MEASURE;
            end
         end
         PUSH: state_s = HOLDOFF;
         HOLDOFF: begin
            if (per_done_s && en) state_s = TRIG;
            else if (per_done_s)  state_s = IDLE;
            else                  state_s = HOLDOFF;
         end
         default: state_s = IDLE;
      endcase
   end

   // State register and trigger-length counter.
   always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) begin
         state_r    <= IDLE;
         trig_cnt_r <= '0;
      end else begin
         state_r <= state_s;
         if (state_s == TRIG && state_r != TRIG) trig_cnt_r <= '0;
         else if (state_r == TRIG)               trig_cnt_r <= trig_cnt_r + TRG_W'(1);
         else                                    trig_cnt_r <= trig_cnt_r;
      end
   end

   // Measurement divider: restarts on entry to WAIT_ECHO and MEASURE, counts only there.
   always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) begin
         meas_div_r <= '0;
         meas_cnt_r <= '0;
      end else if ((state_s == WAIT_ECHO || state_s == MEASURE) && state_s != state_r) begin
         meas_div_r <= '0;
         meas_cnt_r <= '0;
      end else if (state_r == WAIT_ECHO || state_r == MEASURE) begin
         meas_div_r <= meas_tick_s ? '0 : meas_div_r + DIV_W'(1);
         meas_cnt_r <= meas_cnt_r + {{(DATA_WIDTH-1){1'b0}}, meas_tick_s};
      end else begin
         meas_div_r <= meas_div_r;
         meas_cnt_r <= meas_cnt_r;
      end
   end

   // Period timer measured from trigger rise; saturates so HOLDOFF can never miss it.
   always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) begin
         per_div_r <= '0;
         per_cnt_r <= '0;
      end else if (state_s == TRIG && state_r != TRIG) begin
         per_div_r <= '0;
         per_cnt_r <= '0;
      end else begin
         per_div_r <= per_tick_s ? '0 : per_div_r + DIV_W'(1);
         if (per_tick_s && per_cnt_r != PER_END) per_cnt_r <= per_cnt_r + PER_W'(1);
         else                                    per_cnt_r <= per_cnt_r;
      end
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) begin
         trig_r     <= 1'b0;
         busy_r     <= 1'b0;
         wr_r       <= 1'b0;
         wr_data_r  <= '0;
         drop_cnt_r <= 8'd0;
      end else begin
         trig_r <= (state_s == TRIG);
         busy_r <= (state_s != IDLE);
         wr_r   <= (state_s == PUSH) && !fifo.fifo_full;
         if (state_s == PUSH && !fifo.fifo_full) wr_data_r <= sample_s;
         else                                    wr_data_r <= wr_data_r;
         if (state_s == PUSH && fifo.fifo_full && drop_cnt_r != 8'd255)
            drop_cnt_r <= drop_cnt_r + 8'd1;
         else
            drop_cnt_r <= drop_cnt_r;
      end
   end

   assign trig         = trig_r;
   assign busy         = busy_r;
   assign drop_cnt     = drop_cnt_r;
   assign fifo.wr      = wr_r;
   assign fifo.wr_data = wr_data_r;
endmodule

// File: tb/tb_range_ping_ctrl.sv
// Scoreboard bench for range_ping_ctrl: expected samples are queued as echoes are driven and
// matched against samples captured from the FIFO write port.
`timescale 1ns/1ps
module tb_range_ping_ctrl;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rs_n;
   logic en, echo, trig, busy;
   logic [7:0] drop_cnt;
   logic en2, echo2, trig2, busy2;
   logic [7:0] drop2;

   range_ping_ctrl_if #(.DATA_WIDTH(DW)) bus ();
   range_ping_ctrl_if #(.DATA_WIDTH(DW)) bus2 ();

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_total = 0, wr_cyc = 0, wr2_total = 0, rise_cnt = 0, rise2_cnt = 0;
   logic trig_d = 1'b0, trig2_d = 1'b0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] obs_q[$];

   always #5 clk = ~clk;

   range_ping_ctrl #(.DATA_WIDTH(DW), .TICK_DIV(10), .TRIG_CYCLES(5),
                     .TIMEOUT_US(50), .PERIOD_US(120)) dut (
      .clk(clk), .rs_n(rs_n), .en(en), .echo(echo), .fifo(bus),
      .trig(trig), .busy(busy), .drop_cnt(drop_cnt));

   // Short-period instance so the drop counter can be driven to saturation quickly.
   range_ping_ctrl #(.DATA_WIDTH(DW), .TICK_DIV(2), .TRIG_CYCLES(1),
                     .TIMEOUT_US(2), .PERIOD_US(5)) dut2 (
      .clk(clk), .rs_n(rs_n), .en(en2), .echo(echo2), .fifo(bus2),
      .trig(trig2), .busy(busy2), .drop_cnt(drop2));

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor samples 2 ns after the edge: captures writes and counts trigger rises.
   always @(posedge clk) begin
      #2;
      if (bus.wr === 1'b1) begin
         obs_q.push_back(bus.wr_data);
         wr_total++;
         wr_cyc = cyc;
      end
      if (bus2.wr === 1'b1) wr2_total++;
      if (trig === 1'b1 && trig_d !== 1'b1) rise_cnt++;
      if (trig2 === 1'b1 && trig2_d !== 1'b1) rise2_cnt++;
      trig_d  = trig;
      trig2_d = trig2;
   end

   task automatic wait_rise(input int limit, output int c, output bit ok);
      ok = 1'b0;
      c  = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (trig === 1'b1) begin
            ok = 1'b1;
            c  = cyc;
            break;
         end
      end
   endtask

   task automatic measure_high(output int n, output int c);
      n = 0;
      while (trig === 1'b1 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      c = cyc;
   endtask

   task automatic wait_wr(input int base, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (wr_total > base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_rise2(input int target, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (rise2_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rs_n = 1'b1;
      en = 1'b0; echo = 1'b0; bus.fifo_full = 1'b0;
      en2 = 1'b0; echo2 = 1'b0; bus2.fifo_full = 1'b1;
      #1 rs_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         repeat (3) begin
            @(negedge clk);
            en = 1'($urandom_range(1)); echo = 1'($urandom_range(1));
            bus.fifo_full = 1'($urandom_range(1));
         end
         @(negedge clk);
         checks++; if (trig !== 1'b0) begin errors++; $display("FAIL reset_trig got %b required 0", trig); end
         checks++; if (bus.wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b required 0", bus.wr); end
         checks++; if (bus.wr_data !== 16'h0000) begin errors++; $display("FAIL reset_wr_data got %h required 0000", bus.wr_data); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
         checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d required 0", drop_cnt); end
      end
      en = 1'b0; echo = 1'b0; bus.fifo_full = 1'b0;
      @(negedge clk);
      rs_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b0 || trig !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b trig=%b required 0 0", busy, trig); end
   endtask

   task automatic test_drop_saturation();
      bit ok;
      en2 = 1'b1;
      wait_rise2(255, 4000, ok);
      checks++; if (!ok || drop2 !== 8'd254) begin errors++; $display("FAIL drop_254 ok=%b got %0d required 254", ok, drop2); end
      wait_rise2(256, 100, ok);
      checks++; if (!ok || drop2 !== 8'd255) begin errors++; $display("FAIL drop_255 ok=%b got %0d required 255", ok, drop2); end
      wait_rise2(301, 1000, ok);
      checks++; if (!ok || drop2 !== 8'd255) begin errors++; $display("FAIL drop_saturate ok=%b got %0d required 255", ok, drop2); end
      en2 = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (wr2_total !== 0) begin errors++; $display("FAIL drop_no_wr got %0d writes required 0", wr2_total); end
   endtask

   task automatic test_basic(output int r_next);
      int r1, n, c, base;
      bit ok;
      logic [DW-1:0] got, want;
      en = 1'b1;
      exp_q.push_back(16'd20);
      wait_rise(20, r1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_trig_rise timeout trig=%b required 1", trig); end
      measure_high(n, c);
      checks++; if (n !== 5) begin errors++; $display("FAIL trig_width got %0d required 5", n); end
      repeat (30) @(negedge clk);
      echo = 1'b1;
      base = wr_total;
      repeat (205) @(negedge clk);
      echo = 1'b0;
      wait_wr(base, 100, ok);
      checks++;
      if (!ok || obs_q.size() == 0) begin
         errors++; $display("FAIL basic_data no write observed required 20");
      end else begin
         got = obs_q.pop_front(); want = exp_q.pop_front();
         if (got !== want) begin errors++; $display("FAIL basic_data got %0d required %0d", got, want); end
      end
      repeat (20) @(negedge clk);
      checks++; if (wr_total - base !== 1) begin errors++; $display("FAIL basic_single_wr got %0d writes required 1", wr_total - base); end
      wait_rise(1300, r_next, ok);
      checks++; if (!ok || r_next - r1 !== 1200) begin errors++; $display("FAIL ping_period ok=%b got %0d required 1200", ok, r_next - r1); end
   endtask

   task automatic test_timeout();
      int n, c, base;
      bit ok;
      logic [DW-1:0] got, want;
      base = wr_total;
      exp_q.push_back(16'hFFFF);
      measure_high(n, c);
      wait_wr(base, 600, ok);
      checks++; if (!ok || (wr_cyc - c) < 500 || (wr_cyc - c) > 502) begin errors++; $display("FAIL timeout_latency ok=%b got %0d required 500..502", ok, wr_cyc - c); end
      checks++;
      if (obs_q.size() == 0) begin
         errors++; $display("FAIL timeout_data no write observed required ffff");
      end else begin
         got = obs_q.pop_front(); want = exp_q.pop_front();
         if (got !== want) begin errors++; $display("FAIL timeout_data got %h required %h", got, want); end
      end
   endtask

   task automatic test_saturate();
      int r, n, c, base;
      bit ok;
      logic [DW-1:0] got, want;
      wait_rise(1300, r, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sat_trig_rise timeout trig=%b required 1", trig); end
      measure_high(n, c);
      repeat (10) @(negedge clk);
      echo = 1'b1;
      base = wr_total;
      exp_q.push_back(16'hFFFF);
      repeat (800) @(negedge clk);
      echo = 1'b0;
      repeat (30) @(negedge clk);
      checks++; if (wr_total - base !== 1) begin errors++; $display("FAIL sat_single_wr got %0d writes required 1", wr_total - base); end
      checks++;
      if (obs_q.size() == 0) begin
         errors++; $display("FAIL sat_data no write observed required ffff");
      end else begin
         got = obs_q.pop_front(); want = exp_q.pop_front();
         if (got !== want) begin errors++; $display("FAIL sat_data got %h required %h", got, want); end
      end
   endtask

   task automatic test_drop();
      int r, n, c, base;
      bit ok;
      bus.fifo_full = 1'b1;
      base = wr_total;
      for (int p = 0; p < 3; p++) begin
         wait_rise(1300, r, ok);
         checks++; if (!ok) begin errors++; $display("FAIL drop_trig_rise ping %0d timeout required rise", p); end
         measure_high(n, c);
         repeat (520) @(negedge clk);
      end
      checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL drop_count got %0d required 3", drop_cnt); end
      checks++; if (wr_total !== base) begin errors++; $display("FAIL drop_no_wr got %0d writes required 0", wr_total - base); end
      checks++; if (bus.wr_data !== 16'hFFFF) begin errors++; $display("FAIL drop_wr_data_hold got %h required ffff", bus.wr_data); end
      bus.fifo_full = 1'b0;
   endtask

   task automatic test_en_mid();
      int r, n, c, base, rc;
      bit ok;
      logic [DW-1:0] got, want;
      wait_rise(1300, r, ok);
      checks++; if (!ok) begin errors++; $display("FAIL en_trig_rise timeout required rise"); end
      measure_high(n, c);
      repeat (10) @(negedge clk);
      echo = 1'b1;
      base = wr_total;
      exp_q.push_back(16'd12);
      repeat (50) @(negedge clk);
      en = 1'b0;
      repeat (73) @(negedge clk);
      echo = 1'b0;
      wait_wr(base, 100, ok);
      checks++;
      if (!ok || obs_q.size() == 0) begin
         errors++; $display("FAIL en_mid_data no write observed required 12");
      end else begin
         got = obs_q.pop_front(); want = exp_q.pop_front();
         if (got !== want) begin errors++; $display("FAIL en_mid_data got %0d required %0d", got, want); end
      end
      ok = 1'b0;
      for (int i = 0; i < 1300; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL en_mid_idle busy=%b required 0", busy); end
      rc = rise_cnt;
      repeat (1500) @(negedge clk);
      checks++; if (rise_cnt !== rc || busy !== 1'b0) begin errors++; $display("FAIL en_mid_no_trig got %0d rises busy=%b required 0 0", rise_cnt - rc, busy); end
   endtask

   task automatic test_reset_in_trig();
      int r, base, rc;
      bit ok;
      en = 1'b1;
      wait_rise(20, r, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rst_trig_rise timeout required rise"); end
      repeat (2) @(negedge clk);
      rs_n = 1'b0;
      #1;
      checks++; if (trig !== 1'b0) begin errors++; $display("FAIL rst_trig_drop got %b required 0", trig); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
      checks++; if (bus.wr_data !== 16'h0000 || drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_regs wr_data=%h drop=%0d required 0000 0", bus.wr_data, drop_cnt); end
      @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
      rs_n = 1'b1;
      base = wr_total;
      rc = rise_cnt;
      repeat (700) @(negedge clk);
      checks++; if (wr_total !== base || rise_cnt !== rc) begin errors++; $display("FAIL rst_no_wr got %0d writes %0d rises required 0 0", wr_total - base, rise_cnt - rc); end
   endtask

   initial begin
      int r_next;
      test_reset();
      test_drop_saturation();
      test_basic(r_next);
      test_timeout();
      test_saturate();
      test_drop();
      test_en_mid();
      test_reset_in_trig();
      checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover expected=%0d observed=%0d required 0 0", exp_q.size(), obs_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
